// File: rtl/mips_memory_initiator_if.sv
// Core-facing request/response handshakes plus the MIPS_memory control bus.
// slave = the initiator's view; master = the core + memory side.
interface mips_memory_initiator_if;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_req_addr;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [31:0] d_req_addr, d_req_wdata;
  logic        if_resp_valid, if_resp_ready, if_resp_err;
  logic [31:0] if_resp_data;
  logic        d_resp_valid, d_resp_ready, d_resp_err;
  logic [31:0] d_resp_data;
  logic        mem_read, mem_write, mem_write_valid;
  logic [31:0] mem_inst_rd_addr, mem_data_rd_addr;
  logic [31:0] mem_inst_rd_data, mem_data_rd_data;
  logic [31:0] mem_inst_wr_addr, mem_inst_wr_data, mem_data_wr_addr, mem_data_wr_data;

  modport slave (
    input  if_req_valid, if_req_addr, d_req_valid, d_req_we, d_req_addr, d_req_wdata,
           if_resp_ready, d_resp_ready, mem_inst_rd_data, mem_data_rd_data,
    output if_req_ready, d_req_ready, if_resp_valid, if_resp_data, if_resp_err,
           d_resp_valid, d_resp_data, d_resp_err, mem_read, mem_write, mem_write_valid,
           mem_inst_rd_addr, mem_data_rd_addr, mem_inst_wr_addr, mem_inst_wr_data,
           mem_data_wr_addr, mem_data_wr_data
  );

  modport master (
    output if_req_valid, if_req_addr, d_req_valid, d_req_we, d_req_addr, d_req_wdata,
           if_resp_ready, d_resp_ready, mem_inst_rd_data, mem_data_rd_data,
    input  if_req_ready, d_req_ready, if_resp_valid, if_resp_data, if_resp_err,
           d_resp_valid, d_resp_data, d_resp_err, mem_read, mem_write, mem_write_valid,
           mem_inst_rd_addr, mem_data_rd_addr, mem_inst_wr_addr, mem_inst_wr_data,
           mem_data_wr_addr, mem_data_wr_data
  );
endinterface

// File: rtl/mips_memory_initiator.sv
// Initiator for MIPS_memory: latches fetch/data requests, runs one memory access,
// waits out the registered read, then returns per-channel responses.
module mips_memory_initiator #(
  parameter int ADDR_BITS = 5
) (
  input logic                    MIPS_init_clk,
  input logic                    MIPS_init_rst_n,
  mips_memory_initiator_if.slave bus
);
  localparam int PAD = 32 - ADDR_BITS;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t               state;
  logic                 if_pend, if_err, d_pend, d_we, d_err;
  logic [ADDR_BITS-1:0] if_idx, d_idx;
  logic [31:0]          d_wdata;
  logic                 if_rsp_vld, d_rsp_vld, if_rsp_err, d_rsp_err;
  logic [31:0]          if_rsp_data, d_rsp_data;
  logic                 if_done, d_done, f_rd, l_rd, s_wr;

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:ADDR_BITS+2] != '0);
  endfunction

  assign if_done = !if_rsp_vld || bus.if_resp_ready;
  assign d_done  = !d_rsp_vld  || bus.d_resp_ready;

  always_ff @(posedge MIPS_init_clk or negedge MIPS_init_rst_n) begin
    if (!MIPS_init_rst_n) begin
      state       <= IDLE;
      if_pend     <= 1'b0;
      if_err      <= 1'b0;
      d_pend      <= 1'b0;
      d_we        <= 1'b0;
      d_err       <= 1'b0;
      if_idx      <= '0;
      d_idx       <= '0;
      d_wdata     <= '0;
      if_rsp_vld  <= 1'b0;
      d_rsp_vld   <= 1'b0;
      if_rsp_err  <= 1'b0;
      d_rsp_err   <= 1'b0;
      if_rsp_data <= '0;
      d_rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if_pend <= bus.if_req_valid;
          if_err  <= bad_addr(bus.if_req_addr);
          if_idx  <= bus.if_req_addr[ADDR_BITS+1:2];
          d_pend  <= bus.d_req_valid;
          d_we    <= bus.d_req_we;
          d_err   <= bad_addr(bus.d_req_addr);
          d_idx   <= bus.d_req_addr[ADDR_BITS+1:2];
          d_wdata <= bus.d_req_wdata;
          if (bus.if_req_valid || bus.d_req_valid) state <= ACCESS;
        end
        ACCESS: state <= WAIT;
        WAIT: begin
          // memory read data is valid only during this cycle
          if_rsp_vld  <= if_pend;
          d_rsp_vld   <= d_pend;
          if_rsp_err  <= if_pend && if_err;
          d_rsp_err   <= d_pend && d_err;
          if_rsp_data <= (if_pend && !if_err) ? bus.mem_inst_rd_data : '0;
          d_rsp_data  <= (d_pend && !d_err && !d_we) ? bus.mem_data_rd_data : '0;
          state       <= RESP;
        end
        RESP: begin
          if (if_rsp_vld && bus.if_resp_ready) if_rsp_vld <= 1'b0;
          if (d_rsp_vld && bus.d_resp_ready)   d_rsp_vld  <= 1'b0;
          if (if_done && d_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from the state register so an async reset kills an access mid-cycle.
  assign f_rd = (state == ACCESS) && if_pend && !if_err;
  assign l_rd = (state == ACCESS) && d_pend && !d_we && !d_err;
  assign s_wr = (state == ACCESS) && d_pend && d_we && !d_err;

  assign bus.if_req_ready     = (state == IDLE);
  assign bus.d_req_ready      = (state == IDLE);
  assign bus.mem_read         = f_rd || l_rd;
  assign bus.mem_write        = s_wr;
  assign bus.mem_write_valid  = s_wr;
  assign bus.mem_inst_rd_addr = f_rd ? {{PAD{1'b0}}, if_idx} : '0;
  assign bus.mem_data_rd_addr = l_rd ? {{PAD{1'b0}}, d_idx} : '0;
  // both write ports carry the same word so neither can land a stray write
  assign bus.mem_inst_wr_addr = s_wr ? {{PAD{1'b0}}, d_idx} : '0;
  assign bus.mem_data_wr_addr = s_wr ? {{PAD{1'b0}}, d_idx} : '0;
  assign bus.mem_inst_wr_data = s_wr ? d_wdata : '0;
  assign bus.mem_data_wr_data = s_wr ? d_wdata : '0;

  assign bus.if_resp_valid = if_rsp_vld;
  assign bus.if_resp_data  = if_rsp_data;
  assign bus.if_resp_err   = if_rsp_err;
  assign bus.d_resp_valid  = d_rsp_vld;
  assign bus.d_resp_data   = d_rsp_data;
  assign bus.d_resp_err    = d_rsp_err;
endmodule

// File: tb/tb_mips_memory_initiator.sv
// Bench for mips_memory_initiator: memory model, transaction-level reference model,
// per-cycle compare, directed scenarios and randomized traffic with a mid-run reset.
module tb_mips_memory_initiator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_memory_initiator_if bus();

  mips_memory_initiator #(.ADDR_BITS(5)) dut (
    .MIPS_init_clk  (clk),
    .MIPS_init_rst_n(rst_n),
    .bus            (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // MIPS_memory stand-in: registered read, read-before-write on the same edge
  logic [31:0] mem [32] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.mem_read) begin
      bus.mem_inst_rd_data <= mem[bus.mem_inst_rd_addr[4:0]];
      bus.mem_data_rd_data <= mem[bus.mem_data_rd_addr[4:0]];
    end
    if (bus.mem_write) mem[bus.mem_inst_wr_addr[4:0]] <= bus.mem_inst_wr_data;
  end

  // Reference model: each accepted request yields one response, due two edges after
  // acceptance; a good store lands in memory one edge after acceptance unless reset hits first.
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          vcyc;
  } rsp_t;

  rsp_t        fq[$];
  rsp_t        dq[$];
  logic [31:0] smem [32] = '{default: 32'h0};
  int          cyc = 0;
  int          acc_cyc = -100;
  logic        f_good = 1'b0, l_good = 1'b0, s_good = 1'b0;
  logic [4:0]  f_idx = '0, d_idx = '0;
  logic [31:0] s_wd = '0;

  function automatic bit bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd128);
  endfunction

  initial begin : model
    bit idle, eb;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        fq.delete();
        dq.delete();
        acc_cyc = -100;
        f_good = 1'b0; l_good = 1'b0; s_good = 1'b0;
      end else begin
        idle = (fq.size() == 0) && (dq.size() == 0);
        if (fq.size() > 0 && cyc >= fq[0].vcyc && bus.if_resp_ready) void'(fq.pop_front());
        if (dq.size() > 0 && cyc >= dq[0].vcyc && bus.d_resp_ready)  void'(dq.pop_front());
        cyc++;
        if (s_good && cyc == acc_cyc + 1) smem[d_idx] = s_wd;
        if (idle && (bus.if_req_valid || bus.d_req_valid)) begin
          acc_cyc = cyc;
          f_good = 1'b0; l_good = 1'b0; s_good = 1'b0;
          if (bus.if_req_valid) begin
            eb = bad(bus.if_req_addr);
            f_idx = 5'(bus.if_req_addr >> 2);
            f_good = !eb;
            fq.push_back('{eb ? 32'h0 : smem[f_idx], eb, cyc + 2});
          end
          if (bus.d_req_valid) begin
            eb = bad(bus.d_req_addr);
            d_idx = 5'(bus.d_req_addr >> 2);
            if (bus.d_req_we) begin
              s_good = !eb;
              s_wd = bus.d_req_wdata;
              dq.push_back('{32'h0, eb, cyc + 2});
            end else begin
              l_good = !eb;
              dq.push_back('{eb ? 32'h0 : smem[d_idx], eb, cyc + 2});
            end
          end
        end
      end
    end
  end

  initial begin : compare
    bit exp_idle, fv, dv, acc;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_idle = (fq.size() == 0) && (dq.size() == 0);
        fv  = (fq.size() > 0) && (cyc >= fq[0].vcyc);
        dv  = (dq.size() > 0) && (cyc >= dq[0].vcyc);
        acc = (cyc == acc_cyc);
        chk("if_req_ready", bus.if_req_ready, exp_idle);
        chk("d_req_ready", bus.d_req_ready, exp_idle);
        chk("if_resp_valid", bus.if_resp_valid, fv);
        chk("d_resp_valid", bus.d_resp_valid, dv);
        if (fv) begin
          chk("if_resp_data", bus.if_resp_data, fq[0].data);
          chk("if_resp_err", bus.if_resp_err, fq[0].err);
        end
        if (dv) begin
          chk("d_resp_data", bus.d_resp_data, dq[0].data);
          chk("d_resp_err", bus.d_resp_err, dq[0].err);
        end
        chk("mem_read", bus.mem_read, acc && (f_good || l_good));
        chk("mem_write", bus.mem_write, acc && s_good);
        chk("mem_write_valid", bus.mem_write_valid, acc && s_good);
        chk("mem_inst_rd_addr", bus.mem_inst_rd_addr, (acc && f_good) ? 32'(f_idx) : 32'h0);
        chk("mem_data_rd_addr", bus.mem_data_rd_addr, (acc && l_good) ? 32'(d_idx) : 32'h0);
        chk("mem_inst_wr_addr", bus.mem_inst_wr_addr, (acc && s_good) ? 32'(d_idx) : 32'h0);
        chk("mem_data_wr_addr", bus.mem_data_wr_addr, (acc && s_good) ? 32'(d_idx) : 32'h0);
        chk("mem_inst_wr_data", bus.mem_inst_wr_data, (acc && s_good) ? s_wd : 32'h0);
        chk("mem_data_wr_data", bus.mem_data_wr_data, (acc && s_good) ? s_wd : 32'h0);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_req_ready"}, bus.if_req_ready, 1);
    chk({tag, "_d_req_ready"}, bus.d_req_ready, 1);
    chk({tag, "_resp_valids"}, {bus.if_resp_valid, bus.d_resp_valid}, 0);
    chk({tag, "_resp_data"}, bus.if_resp_data | bus.d_resp_data, 0);
    chk({tag, "_resp_err"}, {bus.if_resp_err, bus.d_resp_err}, 0);
    chk({tag, "_mem_ctl"}, {bus.mem_read, bus.mem_write, bus.mem_write_valid}, 0);
    chk({tag, "_rd_addrs"}, bus.mem_inst_rd_addr | bus.mem_data_rd_addr, 0);
    chk({tag, "_wr_bus"}, bus.mem_inst_wr_addr | bus.mem_data_wr_addr |
                          bus.mem_inst_wr_data | bus.mem_data_wr_data, 0);
  endtask

  // called at posedge+1 with the DUT idle; returns at accept edge +1
  task automatic go(input bit fv, input logic [31:0] fa, input bit dv, input bit we,
                    input logic [31:0] da, input logic [31:0] wd);
    bus.if_req_valid = fv;
    bus.if_req_addr  = fa;
    bus.d_req_valid  = dv;
    bus.d_req_we     = we;
    bus.d_req_addr   = da;
    bus.d_req_wdata  = wd;
    @(posedge clk); #1;
    bus.if_req_valid = 1'b0;
    bus.d_req_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (bus.if_req_ready) break;
      @(posedge clk); #1;
    end
    chk("idle_timeout", bus.if_req_ready, 1);
  endtask

  task automatic skip_to_resp();
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    bus.if_req_valid = 0; bus.if_req_addr = 0;
    bus.d_req_valid = 0; bus.d_req_we = 0; bus.d_req_addr = 0; bus.d_req_wdata = 0;
    bus.if_resp_ready = 1; bus.d_resp_ready = 1;
    #1 chk_reset_outputs("por");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // store then load word 3
    go(0, 0, 1, 1, 32'h0C, 32'hDEADBEEF);
    @(negedge clk);
    chk("st_mem_write", bus.mem_write, 1);
    chk("st_inst_wr_addr", bus.mem_inst_wr_addr, 3);
    chk("st_data_wr_addr", bus.mem_data_wr_addr, 3);
    chk("st_wr_data", bus.mem_data_wr_data, 32'hDEADBEEF);
    wait_idle();
    go(0, 0, 1, 0, 32'h0C, 0);
    @(negedge clk); chk("ld_valid_access", bus.d_resp_valid, 0);
    @(negedge clk); chk("ld_valid_wait", bus.d_resp_valid, 0);
    @(negedge clk); chk("ld_valid_lat3", bus.d_resp_valid, 1);
    chk("ld_data", bus.d_resp_data, 32'hDEADBEEF);
    chk("ld_err", bus.d_resp_err, 0);
    wait_idle();

    // fetch alongside a store to the same word sees the old contents
    go(1, 32'h0C, 1, 1, 32'h0C, 32'h12345678);
    skip_to_resp();
    chk("rbw_fetch_old", bus.if_resp_data, 32'hDEADBEEF);
    chk("rbw_store_data0", bus.d_resp_data, 0);
    wait_idle();
    go(1, 32'h0C, 0, 0, 0, 0);
    skip_to_resp();
    chk("fetch_new", bus.if_resp_data, 32'h12345678);
    wait_idle();

    // error accesses never touch memory
    go(0, 0, 1, 0, 32'h0D, 0);
    @(negedge clk); chk("mis_ld_mem_read", bus.mem_read, 0);
    repeat (2) @(negedge clk);
    chk("mis_ld_err", bus.d_resp_err, 1);
    chk("mis_ld_data", bus.d_resp_data, 0);
    wait_idle();
    go(0, 0, 1, 1, 32'h80, 32'h55555555);
    @(negedge clk); chk("oor_st_mem_write", bus.mem_write, 0);
    repeat (2) @(negedge clk);
    chk("oor_st_err", bus.d_resp_err, 1);
    wait_idle();

    // data response back-pressured while fetch response drains
    bus.d_resp_ready = 0;
    go(1, 32'h0C, 1, 0, 32'h0C, 0);
    skip_to_resp();
    chk("bp_if_valid", bus.if_resp_valid, 1);
    chk("bp_d_valid", bus.d_resp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_if_done", bus.if_resp_valid, 0);
      chk("bp_d_hold_valid", bus.d_resp_valid, 1);
      chk("bp_d_hold_data", bus.d_resp_data, 32'h12345678);
      chk("bp_ready_low", bus.if_req_ready | bus.d_req_ready, 0);
    end
    bus.d_resp_ready = 1;
    @(posedge clk); #1;
    chk("bp_idle_after", bus.d_req_ready, 1);

    // reset during the ACCESS cycle of a store must cancel it
    go(0, 0, 1, 1, 32'h04, 32'h11112222);
    wait_idle();
    go(0, 0, 1, 1, 32'h04, 32'hCAFEF00D);
    chk("rst_st_write_pre", bus.mem_write, 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_access");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    go(0, 0, 1, 0, 32'h04, 0);
    skip_to_resp();
    chk("rst_st_cancelled", bus.d_resp_data, 32'h11112222);
    wait_idle();

    // randomized traffic with a reset dropped in the middle
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      bus.if_req_valid  = ($urandom_range(0, 9) < 3);
      bus.d_req_valid   = ($urandom_range(0, 9) < 4);
      bus.d_req_we      = $urandom_range(0, 1);
      bus.d_req_wdata   = $urandom;
      bus.if_resp_ready = ($urandom_range(0, 9) < 7);
      bus.d_resp_ready  = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < 2; c++) begin
        logic [31:0] a;
        a = 32'($urandom_range(0, 7)) * 4;
        case ($urandom_range(0, 7))
          0: a = a + 32'($urandom_range(1, 3));
          1: a = 32'h80 + 32'($urandom_range(0, 255)) * 4;
          default: ;
        endcase
        if (c == 0) bus.if_req_addr = a;
        else        bus.d_req_addr  = a;
      end
      if (i == 300) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_random");
      end
      if (i == 302) #2 rst_n = 1'b1;
    end
    bus.if_req_valid = 0;
    bus.d_req_valid = 0;
    bus.if_resp_ready = 1;
    bus.d_resp_ready = 1;
    @(posedge clk); #1;
    wait_idle();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
